// File: rtl/cbus_axi_pkg.sv
// Shared types and constants for the cbus to AXI3 bridge.
// Holds the cbus request/response structs used on the cache-manager side,
// the AXI burst/response encodings and the bridge FSM state type.
package cbus_axi_pkg;

    // Only INCR bursts are ever issued.
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    typedef enum logic [1:0] {
        AXI_RESP_OKAY   = 2'b00,
        AXI_RESP_EXOKAY = 2'b01,
        AXI_RESP_SLVERR = 2'b10,
        AXI_RESP_DECERR = 2'b11
    } axi_resp_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        AR   = 3'd1,
        R    = 3'd2,
        AW   = 3'd3,
        W    = 3'd4,
        B    = 3'd5
    } bridge_state_t;

    // len is beats-1; data/strobe carry the current write beat.
    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] data;
        logic [3:0]  len;
    } cbus_req_t;

    // One ready pulse per accepted beat; last marks end of transaction.
    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

endpackage

// File: rtl/cbus_axi_bridge.sv
// cbus to AXI3 master bridge.
// Turns the single cbus request stream from the cache arbiter into AXI3 AR/R/AW/W/B
// traffic, one outstanding INCR burst at a time.
// Build option: CBUS_AXI_BRESP_WAIT_EN - when defined, the write is reported complete
// (cresp.last) only on the B response; otherwise on the final W handshake, with the
// B response absorbed silently before the next request is accepted.
module cbus_axi_bridge
    import cbus_axi_pkg::*;
#(
    parameter int unsigned ID_W  = 4,
    parameter int unsigned RD_ID = 0,
    parameter int unsigned WR_ID = 1
) (
    input  logic            clk,
    input  logic            resetn,

    input  cbus_req_t       creq,
    output cbus_resp_t      cresp,

    output logic [ID_W-1:0] arid,
    output logic [31:0]     araddr,
    output logic [3:0]      arlen,
    output logic [2:0]      arsize,
    output logic [1:0]      arburst,
    output logic            arvalid,
    input  logic            arready,

    input  logic [ID_W-1:0] rid,
    input  logic [31:0]     rdata,
    input  logic [1:0]      rresp,
    input  logic            rlast,
    input  logic            rvalid,
    output logic            rready,

    output logic [ID_W-1:0] awid,
    output logic [31:0]     awaddr,
    output logic [3:0]      awlen,
    output logic [2:0]      awsize,
    output logic [1:0]      awburst,
    output logic            awvalid,
    input  logic            awready,

    output logic [ID_W-1:0] wid,
    output logic [31:0]     wdata,
    output logic [3:0]      wstrb,
    output logic            wlast,
    output logic            wvalid,
    input  logic            wready,

    input  logic [ID_W-1:0] bid,
    input  logic [1:0]      bresp,
    input  logic            bvalid,
    output logic            bready
);

    bridge_state_t state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [31:0]   addr_q, addr_d;
    logic [3:0]    len_q, len_d;
    logic [2:0]    size_q, size_d;
    logic          w_final;

    // Response IDs and codes carry no information for a single-outstanding master.
    logic unused_inputs;
    assign unused_inputs = ^{rid, rresp, bid, bresp};

    // Final write beat of the burst is reached when the counter matches len.
    assign w_final = (cnt_q == len_q);

    // Next-state logic: FSM transitions, beat counter and request capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        len_d   = len_q;
        size_d  = size_q;
        unique case (state_q)
            IDLE: begin
                if (creq.valid) begin
                    state_d = creq.is_write ? AW : AR;
                    // Address phase fields are held in flops so they stay stable
                    // while the slave stalls, whatever upstream does meanwhile.
                    addr_d  = creq.addr;
                    len_d   = creq.len;
                    size_d  = creq.size;
                end
            end
            AR: begin
                if (arready) begin
                    state_d = R;
                    cnt_d   = '0;
                end
            end
            R: begin
                if (rvalid && rlast) begin
                    state_d = IDLE;
                end
            end
            AW: begin
                if (awready) begin
                    state_d = W;
                    cnt_d   = '0;
                end
            end
            W: begin
                if (wready) begin
                    if (w_final) begin
                        state_d = B;
                    end else begin
                        // len <= 15, so the final beat never needs to increment.
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            B: begin
                if (bvalid) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset; reset abandons any burst.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            size_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            size_q  <= size_d;
        end
    end

    // Address and write-data channel payloads; validity comes from the state decode.
    assign arid    = ID_W'(RD_ID);
    assign araddr  = addr_q;
    assign arlen   = len_q;
    assign arsize  = size_q;
    assign arburst = AXI_BURST_INCR;

    assign awid    = ID_W'(WR_ID);
    assign awaddr  = addr_q;
    assign awlen   = len_q;
    assign awsize  = size_q;
    assign awburst = AXI_BURST_INCR;

    assign wid     = ID_W'(WR_ID);
    assign wdata   = creq.data;
    assign wstrb   = creq.strobe;

    // Handshake and cbus response decode; R and W beats pass straight through.
    always_comb begin
        arvalid = 1'b0;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        wlast   = 1'b0;
        rready  = 1'b0;
        bready  = 1'b0;
        cresp   = '0;
        unique case (state_q)
            AR: begin
                arvalid = 1'b1;
            end
            R: begin
                rready      = 1'b1;
                cresp.ready = rvalid;
                cresp.last  = rvalid & rlast;
                cresp.data  = rdata;
            end
            AW: begin
                awvalid = 1'b1;
            end
            W: begin
                wvalid      = 1'b1;
                wlast       = w_final;
                cresp.ready = wready;
`ifdef CBUS_AXI_BRESP_WAIT_EN
                cresp.last  = 1'b0;
`else
                cresp.last  = wready & w_final;
`endif
            end
            B: begin
                bready = 1'b1;
`ifdef CBUS_AXI_BRESP_WAIT_EN
                // Write is only reported complete once the slave has responded.
                cresp.ready = bvalid;
                cresp.last  = bvalid;
`endif
            end
            default: begin
                cresp = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_cbus_axi_bridge.sv
// Self-checking bench for cbus_axi_bridge: random and directed cbus requests against a
// behavioural AXI slave; expected AXI payloads and cbus responses go into queues that a
// separate monitor pops on every handshake.
module tb_cbus_axi_bridge;
    import cbus_axi_pkg::*;

    localparam int unsigned ID_W  = 4;
    localparam int unsigned RD_ID = 0;
    localparam int unsigned WR_ID = 1;
`ifdef CBUS_AXI_BRESP_WAIT_EN
    localparam bit BWAIT = 1'b1;
`else
    localparam bit BWAIT = 1'b0;
`endif

    logic clk = 1'b0;
    logic resetn = 1'b0;
    cbus_req_t  creq;
    cbus_resp_t cresp;
    logic [ID_W-1:0] arid, awid, wid, rid, bid;
    logic [31:0] araddr, awaddr, wdata, rdata;
    logic [3:0]  arlen, awlen, wstrb;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst, rresp, bresp;
    logic arvalid, arready, rlast, rvalid, rready, awvalid, awready;
    logic wlast, wvalid, wready, bvalid, bready;

    always #5 clk = ~clk;

    cbus_axi_bridge #(.ID_W(ID_W), .RD_ID(RD_ID), .WR_ID(WR_ID)) dut (
        .clk(clk), .resetn(resetn), .creq(creq), .cresp(cresp),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
        .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [31:0]     addr;
        logic [3:0]      len;
        logic [2:0]      size;
        logic [1:0]      burst;
    } addr_exp_t;
    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [31:0]     data;
        logic [3:0]      strb;
        logic            last;
    } w_exp_t;
    typedef struct {
        bit          rd;
        logic        last;
        logic [31:0] data;
    } resp_exp_t;

    addr_exp_t ar_q[$];
    addr_exp_t aw_q[$];
    w_exp_t    w_q[$];
    resp_exp_t resp_q[$];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Slave knobs and the length of the most recently issued request.
    int ar_delay = 0, aw_delay = 0, r_mode = 0, w_mode = 0, b_delay = 0;
    bit r_force = 1'b0;
    logic [31:0] r_force_data = '0;
    int cur_len = 0;

    // Behavioural AXI slave: observe at negedge, drive just after posedge.
    initial begin
        int ar_cnt, aw_cnt, r_left, w_left, b_cnt;
        bit r_act, w_act, b_due, r_phase, r_hs, r_pend, b_pend, in_rst, present;
        ar_cnt = 0; aw_cnt = 0; r_left = 0; w_left = 0; b_cnt = 0;
        r_act = 0; w_act = 0; b_due = 0; r_phase = 0; r_pend = 0; b_pend = 0;
        arready = 0; awready = 0; wready = 0; rvalid = 0; rlast = 0; rdata = '0;
        rid = '0; rresp = '0; bvalid = 0; bid = '0; bresp = '0;
        forever begin
            @(negedge clk);
            r_hs = 0;
            in_rst = !resetn;
            if (in_rst) begin
                ar_cnt = 0; aw_cnt = 0; r_act = 0; w_act = 0; b_due = 0; b_cnt = 0;
                r_phase = 0; r_pend = 0; b_pend = 0;
            end else begin
                if (arvalid && arready) begin
                    r_act = 1; r_left = cur_len + 1; ar_cnt = 0;
                end else if (arvalid) begin
                    ar_cnt++;
                end
                if (r_act && r_pend && rvalid && rready) begin
                    r_hs = 1; r_pend = 0; r_left--;
                    if (r_left == 0) r_act = 0;
                end
                if (awvalid && awready) begin
                    w_act = 1; w_left = cur_len + 1; aw_cnt = 0;
                end else if (awvalid) begin
                    aw_cnt++;
                end
                if (w_act && wvalid && wready) begin
                    w_left--;
                    if (w_left == 0) begin
                        w_act = 0; b_due = 1; b_cnt = 0;
                    end
                end
                if (b_due && b_pend && bvalid && bready) begin
                    b_due = 0; b_pend = 0;
                end else if (b_due && !b_pend) begin
                    b_cnt++;
                end
            end
            @(posedge clk);
            #1;
            if (in_rst) begin
                arready = 0; awready = 0; wready = 0; rvalid = 0; rlast = 0; bvalid = 0;
            end else begin
                arready = (ar_cnt >= ar_delay);
                awready = (aw_cnt >= aw_delay);
                wready  = (w_mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
                rid     = ID_W'($urandom);
                rresp   = 2'($urandom);
                bid     = ID_W'($urandom);
                bresp   = 2'($urandom);
                if (r_act) begin
                    if (!r_pend) begin
                        case (r_mode)
                            0: present = 1'b1;
                            1: begin present = r_phase; r_phase = !r_phase; end
                            default: present = 1'($urandom_range(0, 1));
                        endcase
                        if (present) begin
                            rdata  = r_force ? r_force_data : $urandom;
                            rlast  = (r_left == 1);
                            r_pend = 1;
                            resp_q.push_back('{rd: 1'b1, last: (r_left == 1), data: rdata});
                        end
                        rvalid = present;
                    end
                end else begin
                    // Stray R traffic outside a read must be ignored by the bridge.
                    rvalid = ($urandom_range(0, 3) == 0);
                    rlast  = 1'($urandom_range(0, 1));
                    rdata  = $urandom;
                end
                if (b_due) begin
                    if (!b_pend && b_cnt >= b_delay) b_pend = 1;
                    bvalid = b_pend;
                end else begin
                    bvalid = ($urandom_range(0, 3) == 0);
                end
            end
        end
    end

    // Monitor: pop and compare on every handshake and cbus response beat.
    initial begin
        bit b_out, ar_stall, aw_stall;
        addr_exp_t ar_prev, aw_prev, ar_now, aw_now, e_a;
        w_exp_t w_now, e_w;
        resp_exp_t e_r;
        b_out = 0; ar_stall = 0; aw_stall = 0; ar_prev = '0; aw_prev = '0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                b_out = 0; ar_stall = 0; aw_stall = 0;
                ar_q.delete(); aw_q.delete(); w_q.delete(); resp_q.delete();
            end else begin
                ar_now = '{arid, araddr, arlen, arsize, arburst};
                aw_now = '{awid, awaddr, awlen, awsize, awburst};
                w_now  = '{wid, wdata, wstrb, wlast};
                chk("ar_aw_exclusive", 64'(arvalid & awvalid), 64'd0);
                if (b_out) chk("no_addr_while_b", 64'(arvalid | awvalid), 64'd0);
                if (ar_stall) chk("ar_hold", 64'({arvalid, ar_now}), 64'({1'b1, ar_prev}));
                if (aw_stall) chk("aw_hold", 64'({awvalid, aw_now}), 64'({1'b1, aw_prev}));
                ar_stall = arvalid && !arready;
                aw_stall = awvalid && !awready;
                ar_prev = ar_now;
                aw_prev = aw_now;
                if (arvalid && arready) begin
                    if (ar_q.size() == 0) fail_now("ar_unexpected");
                    else begin e_a = ar_q.pop_front(); chk("ar_fields", 64'(ar_now), 64'(e_a)); end
                end
                if (awvalid && awready) begin
                    if (aw_q.size() == 0) fail_now("aw_unexpected");
                    else begin e_a = aw_q.pop_front(); chk("aw_fields", 64'(aw_now), 64'(e_a)); end
                end
                if (wvalid && wready) begin
                    if (w_q.size() == 0) fail_now("w_unexpected");
                    else begin
                        e_w = w_q.pop_front();
                        chk("w_beat", 64'(w_now), 64'(e_w));
                        if (e_w.last) b_out = 1;
                    end
                end
                if (b_out && bvalid && bready) b_out = 0;
                if (cresp.ready) begin
                    if (resp_q.size() == 0) fail_now("cresp_unexpected");
                    else begin
                        e_r = resp_q.pop_front();
                        chk("cresp_last", 64'(cresp.last), 64'(e_r.last));
                        if (e_r.rd) chk("cresp_data", 64'(cresp.data), 64'(e_r.data));
                    end
                end
            end
        end
    end

    // Apply reset from just after a posedge; checks the bridge comes out idle.
    task automatic do_reset(input int cycles);
        creq.valid = 1'b0;
        resetn = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        chk("reset_idle", 64'({arvalid, awvalid, wvalid, rready, bready, cresp}),
            64'd0);
        @(posedge clk);
        #1;
    endtask

    // Issue one cbus request and act as the upstream master until cresp.last.
    task automatic do_req(input bit wr, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [3:0] strb, input bit pat,
                          input int abort_at, input int exp_alat, input int exp_rlat);
        logic [31:0] wd[17];
        int k, cyc, alat, rlat;
        bit done;
        k = 0; cyc = 0; alat = 0; rlat = 0; done = 0;
        for (int i = 0; i < 17; i++) wd[i] = pat ? 32'((i + 1) * 32'h11) : $urandom;
        cur_len = int'(len);
        creq.valid = 1'b1; creq.is_write = wr; creq.size = size; creq.addr = addr;
        creq.strobe = strb; creq.data = wd[0]; creq.len = len;
        if (!wr) begin
            ar_q.push_back('{ID_W'(RD_ID), addr, len, size, 2'b01});
        end else begin
            aw_q.push_back('{ID_W'(WR_ID), addr, len, size, 2'b01});
            for (int i = 0; i <= int'(len); i++) begin
                w_q.push_back('{ID_W'(WR_ID), wd[i], strb, (i == int'(len))});
                resp_q.push_back('{rd: 1'b0, last: (!BWAIT && i == int'(len)), data: '0});
            end
            if (BWAIT) resp_q.push_back('{rd: 1'b0, last: 1'b1, data: '0});
        end
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (alat == 0 && (arvalid || awvalid)) alat = cyc;
            if (cresp.ready) begin
                if (rlat == 0) rlat = cyc;
                k++;
                if (cresp.last) done = 1;
            end
            @(posedge clk);
            #1;
            creq.data = wd[(k > 16) ? 16 : k];
            if (abort_at > 0 && k >= abort_at) break;
        end
        creq.valid = 1'b0;
        if (abort_at > 0) begin
            do_reset(1);
        end else if (!done) begin
            fail_now("transaction_timeout");
            do_reset(2);
        end else begin
            if (exp_alat > 0) chk("addr_latency", 64'(alat), 64'(exp_alat));
            if (exp_rlat > 0) chk("resp_latency", 64'(rlat), 64'(exp_rlat));
            chk("beat_count", 64'(k), 64'(int'(len) + 1 + ((wr && BWAIT) ? 1 : 0)));
        end
    endtask

    initial begin
        bit idle_next, wr;
        creq = '0;
        do_reset(3);

        // 1: single-beat read, zero-wait slave, minimum latency
        ar_delay = 0; r_mode = 0; r_force = 1; r_force_data = 32'hdead_beef;
        do_req(0, 32'h1fc0_0000, 4'd0, 3'd2, 4'hf, 0, 0, 2, 3);
        r_force = 0;

        // 2: 16-beat read, stalled AR, rvalid every other cycle
        ar_delay = 3; r_mode = 1;
        do_req(0, 32'h0000_1000, 4'd15, 3'd2, 4'hf, 0, 0, 2, 0);

        // 3: 4-beat write with wready gaps and a slow B, then a read right behind it
        ar_delay = 0; r_mode = 0; aw_delay = 0; w_mode = 1; b_delay = 5;
        do_req(1, 32'h0000_2000, 4'd3, 3'd2, 4'hf, 1, 0, 2, 0);
        do_req(0, 32'h0000_2000, 4'd1, 3'd2, 4'hf, 0, 0, BWAIT ? 2 : 0, 0);

        // 4: single-beat partial-strobe write
        w_mode = 0; b_delay = 0;
        do_req(1, 32'h0000_3004, 4'd0, 3'd1, 4'b0011, 0, 0, 2, 0);

        // 5: reset in the middle of an 8-beat read, then a short read
        do_req(0, 32'h0000_4000, 4'd7, 3'd2, 4'hf, 0, 2, 0, 0);
        do_req(0, 32'h0000_5000, 4'd1, 3'd2, 4'hf, 0, 0, 2, 3);

        // 6: read immediately followed by write, one idle cycle between
        do_req(0, 32'h0000_6000, 4'd2, 3'd2, 4'hf, 0, 0, 2, 3);
        do_req(1, 32'h0000_7000, 4'd2, 3'd2, 4'hf, 0, 0, 2, 0);

        // Randomised mix of reads and writes with random slave behaviour
        idle_next = BWAIT;
        for (int n = 0; n < 40; n++) begin
            ar_delay = $urandom_range(0, 3);
            aw_delay = $urandom_range(0, 3);
            r_mode   = $urandom_range(0, 2);
            w_mode   = $urandom_range(0, 1);
            b_delay  = $urandom_range(0, 4);
            wr = 1'($urandom_range(0, 1));
            do_req(wr, $urandom & 32'hffff_fffc, 4'($urandom_range(0, 15)),
                   3'($urandom_range(0, 2)), 4'($urandom_range(1, 15)), 0, 0,
                   idle_next ? 2 : 0, 0);
            idle_next = !(wr && !BWAIT);
        end

        repeat (20) @(posedge clk);
        #1;
        chk("queues_drained", 64'(ar_q.size() + aw_q.size() + w_q.size() + resp_q.size()),
            64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog expired at %0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

endmodule
